mem_access_unit: RTL and testbench

Memory-stage controller that consumes the EX/MEM pipeline outputs (alu_result, sw_data, MemRead/MemWrite, call, ret_future, reg_rd) and turns them into data-memory transactions over a req/ack handshake. It stalls the front of the pipeline while a transaction is outstanding and registers results into the MEM/WB stage. It closes the call/return loop back to EX: a call pushes the PC (sw_data) to the stack, and a ret pops it and returns it to the PC updater as ret_wb/PC_stack_pointer.

---
 rtl/wisc_pkg.sv | 11 +
 rtl/mem_access_unit_mem_wb_reg.sv | 68 ++++++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the memory stage: state encoding, data width and the
// register index used as the stack pointer for call/ret.
package wisc_pkg;
   localparam int         DATA_W = 16;
   localparam logic [3:0] SP_REG = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } mem_state_t;
endpackage

// File: rtl/mem_access_unit_mem_wb_reg.sv
// MEM/WB pipeline register. A cycle without load_en inserts a bubble; the
// popped return PC is only updated by a completing ret.
module mem_wb_reg
   import wisc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              reg_write_d,
   input  logic              mem_to_reg_d,
   input  logic              ret_wb_d,
   input  logic [3:0]        reg_rd_d,
   input  logic [DATA_W-1:0] mem_data_d,
   input  logic [DATA_W-1:0] alu_result_d,
   output logic              valid_out,
   output logic              RegWrite_out,
   output logic              mem_to_reg_out,
   output logic              ret_wb,
   output logic [3:0]        reg_rd_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] PC_stack_pointer
);
   logic              valid_reg;
   logic              reg_write_reg;
   logic              mem_to_reg_reg;
   logic              ret_wb_reg;
   logic [3:0]        reg_rd_reg;
   logic [DATA_W-1:0] mem_data_reg;
   logic [DATA_W-1:0] alu_result_reg;
   logic [DATA_W-1:0] pc_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg      <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         ret_wb_reg     <= 1'b0;
         reg_rd_reg     <= '0;
         mem_data_reg   <= '0;
         alu_result_reg <= '0;
         pc_reg         <= '0;
      end else if (load_en) begin
         valid_reg      <= 1'b1;
         reg_write_reg  <= reg_write_d;
         mem_to_reg_reg <= mem_to_reg_d;
         ret_wb_reg     <= ret_wb_d;
         reg_rd_reg     <= reg_rd_d;
         mem_data_reg   <= mem_data_d;
         alu_result_reg <= alu_result_d;
         if (ret_wb_d) pc_reg <= mem_data_d;
      end else begin
         // Bubble: nothing may be written back, data fields hold
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         ret_wb_reg    <= 1'b0;
      end
   end

   assign valid_out        = valid_reg;
   assign RegWrite_out     = reg_write_reg;
   assign mem_to_reg_out   = mem_to_reg_reg;
   assign ret_wb           = ret_wb_reg;
   assign reg_rd_out       = reg_rd_reg;
   assign mem_data_out     = mem_data_reg;
   assign alu_result_out   = alu_result_reg;
   assign PC_stack_pointer = pc_reg;
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: req/ack data-memory handshake, front-end stall and
// call/ret stack traffic. Optional request timeout enabled by MEM_TIMEOUT_EN.
module mem_access_unit
   import wisc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              RegWrite_in,
   input  logic              MemWrite_in,
   input  logic              MemRead_in,
   input  logic              mem_to_reg_in,
   input  logic              call_in,
   input  logic              ret_future_in,
   input  logic [3:0]        reg_rd_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] sw_data,
   output logic              stall_out,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              valid_out,
   output logic              RegWrite_out,
   output logic              mem_to_reg_out,
   output logic [3:0]        reg_rd_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic              ret_wb,
   output logic [DATA_W-1:0] PC_stack_pointer,
   output logic              mem_err
);
   mem_state_t        state_reg, state_next;
   logic              mem_op, capture;
   logic              we_reg, ret_reg, reg_write_reg, mem_to_reg_reg;
   logic [3:0]        rd_reg;
   logic [DATA_W-1:0] addr_reg, wdata_reg;
   logic              wb_load, wb_reg_write, wb_mem_to_reg, wb_ret;
   logic [3:0]        wb_rd;
   logic [DATA_W-1:0] wb_data, wb_alu;

   assign mem_op = valid_in & (MemRead_in | MemWrite_in | call_in | ret_future_in);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             mem_err_reg, timeout_now, timeout_hit;

   assign timeout_now = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
         mem_err_reg  <= 1'b0;
      end else begin
         if (capture) wait_cnt_reg <= '0;
         else if (state_reg == REQ) wait_cnt_reg <= wait_cnt_reg + 1'b1;
         if (timeout_hit) mem_err_reg <= 1'b1;
      end
   end

   assign mem_err = mem_err_reg;
`else
   assign mem_err = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      capture       = 1'b0;
      wb_load       = 1'b0;
      stall_out     = 1'b0;
      dmem_req      = 1'b0;
      wb_reg_write  = RegWrite_in;
      wb_mem_to_reg = mem_to_reg_in;
      wb_rd         = reg_rd_in;
      wb_alu        = alu_result;
      wb_data       = '0;
      wb_ret        = 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout_hit   = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (mem_op) begin
               capture    = 1'b1;
               stall_out  = 1'b1;
               state_next = REQ;
            end else if (valid_in) begin
               wb_load = 1'b1;
            end
         end
         REQ: begin
            stall_out     = 1'b1;
            dmem_req      = 1'b1;
            wb_reg_write  = reg_write_reg;
            wb_mem_to_reg = mem_to_reg_reg;
            wb_rd         = rd_reg;
            wb_alu        = addr_reg;
            wb_data       = we_reg ? '0 : dmem_rdata;
            wb_ret        = ret_reg & ~we_reg;
            if (dmem_ack) begin
               wb_load    = 1'b1;
               state_next = IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timeout_now) begin
               // Abort: complete the slot with a poisoned, non-writing result
               wb_load      = 1'b1;
               wb_data      = '1;
               wb_reg_write = 1'b0;
               wb_ret       = 1'b0;
               timeout_hit  = 1'b1;
               state_next   = IDLE;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         we_reg         <= 1'b0;
         ret_reg        <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         rd_reg         <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            we_reg         <= MemWrite_in | call_in;
            ret_reg        <= ret_future_in;
            reg_write_reg  <= RegWrite_in;
            mem_to_reg_reg <= mem_to_reg_in;
            rd_reg         <= (call_in | ret_future_in) ? SP_REG : reg_rd_in;
            addr_reg       <= alu_result;
            wdata_reg      <= sw_data;
         end
      end
   end

   assign dmem_we    = we_reg;
   assign dmem_addr  = addr_reg;
   assign dmem_wdata = wdata_reg;

   mem_wb_reg u_mem_wb_reg (
      .clk              (clk),
      .rst_n            (rst_n),
      .load_en          (wb_load),
      .reg_write_d      (wb_reg_write),
      .mem_to_reg_d     (wb_mem_to_reg),
      .ret_wb_d         (wb_ret),
      .reg_rd_d         (wb_rd),
      .mem_data_d       (wb_data),
      .alu_result_d     (wb_alu),
      .valid_out        (valid_out),
      .RegWrite_out     (RegWrite_out),
      .mem_to_reg_out   (mem_to_reg_out),
      .ret_wb           (ret_wb),
      .reg_rd_out       (reg_rd_out),
      .mem_data_out     (mem_data_out),
      .alu_result_out   (alu_result_out),
      .PC_stack_pointer (PC_stack_pointer)
   );
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level model of writebacks
// and handshake phases, checked every cycle, plus hand-computed pins.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in, RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, call_in, ret_future_in;
   logic [3:0]  reg_rd_in;
   logic [15:0] alu_result, sw_data, dmem_rdata;
   logic        dmem_ack;
   logic        stall_out, dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic        valid_out, RegWrite_out, mem_to_reg_out, ret_wb, mem_err;
   logic [3:0]  reg_rd_out;
   logic [15:0] mem_data_out, alu_result_out, PC_stack_pointer;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .RegWrite_in(RegWrite_in),
      .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .mem_to_reg_in(mem_to_reg_in),
      .call_in(call_in), .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
      .alu_result(alu_result), .sw_data(sw_data), .stall_out(stall_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .valid_out(valid_out), .RegWrite_out(RegWrite_out), .mem_to_reg_out(mem_to_reg_out),
      .reg_rd_out(reg_rd_out), .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
      .ret_wb(ret_wb), .PC_stack_pointer(PC_stack_pointer), .mem_err(mem_err)
   );

   typedef struct {
      int          cyc;
      logic        rw, m2r, chk_data, ret, tmo;
      logic [3:0]  rd;
      logic [15:0] alu, data;
   } wb_t;

   wb_t         wbq[$];
   wb_t         cmp_e;
   int          tests = 0, fails = 0, cyc = 0;
   int          req_hi = 0, stall_hi = 0, valid_hi = 0;
   logic        chk_en = 1'b0;
   logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
   logic [15:0] exp_addr = '0, exp_wdata = '0, model_pc = '0;
   logic        model_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall_out) stall_hi++;
         if (dmem_req)  req_hi++;
         if (valid_out) valid_hi++;
         check("stall_out", stall_out, exp_stall);
         check("dmem_req", dmem_req, exp_req);
         if (exp_req) begin
            check("dmem_we", dmem_we, exp_we);
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
            cmp_e = wbq.pop_front();
            if (cmp_e.ret) model_pc = cmp_e.data;
            if (cmp_e.tmo) model_err = 1'b1;
            check("valid_out", valid_out, 1'b1);
            check("RegWrite_out", RegWrite_out, cmp_e.rw);
            check("mem_to_reg_out", mem_to_reg_out, cmp_e.m2r);
            check("reg_rd_out", reg_rd_out, cmp_e.rd);
            check("alu_result_out", alu_result_out, cmp_e.alu);
            if (cmp_e.chk_data) check("mem_data_out", mem_data_out, cmp_e.data);
            check("ret_wb", ret_wb, cmp_e.ret);
         end else begin
            check("valid_out_bubble", valid_out, 1'b0);
            check("ret_wb_idle", ret_wb, 1'b0);
         end
         check("PC_stack_pointer", PC_stack_pointer, model_pc);
         check("mem_err", mem_err, model_err);
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      valid_in = 0; MemRead_in = 0; MemWrite_in = 0; call_in = 0; ret_future_in = 0;
      RegWrite_in = 0; mem_to_reg_in = 0; dmem_ack = 0;
      exp_stall = 0; exp_req = 0;
      repeat (n) next();
   endtask

   task automatic alu_op(input logic [3:0] rd, input logic [15:0] val, input logic rw);
      wb_t e;
      valid_in = 1; MemRead_in = 0; MemWrite_in = 0; call_in = 0; ret_future_in = 0;
      RegWrite_in = rw; mem_to_reg_in = 0; reg_rd_in = rd; alu_result = val; sw_data = ~val;
      dmem_ack = 0; exp_stall = 0; exp_req = 0;
      e.cyc = cyc + 1; e.rw = rw; e.m2r = 0; e.rd = rd; e.alu = val; e.data = '0;
      e.chk_data = 0; e.ret = 0; e.tmo = 0;
      wbq.push_back(e);
      next();
   endtask

   task automatic mem_op(input logic rd_f, wr_f, call_f, ret_f, rw, m2r, input logic [3:0] rd,
                         input logic [15:0] addr, wdata, input int wait_n,
                         input logic [15:0] rdata, input logic give_ack);
      logic wr;
      wb_t  e;
      wr = wr_f | call_f;
      valid_in = 1; MemRead_in = rd_f; MemWrite_in = wr_f; call_in = call_f; ret_future_in = ret_f;
      RegWrite_in = rw; mem_to_reg_in = m2r; reg_rd_in = rd; alu_result = addr; sw_data = wdata;
      dmem_ack = 0; exp_stall = 1; exp_req = 0;
      next();
      for (int i = 0; i <= wait_n; i++) begin
         exp_req = 1; exp_we = wr; exp_addr = addr; exp_wdata = wdata;
         dmem_ack   = give_ack && (i == wait_n);
         dmem_rdata = (i == wait_n) ? rdata : 16'h5A5A;
         if (i == wait_n) begin
            e.cyc = cyc + 1; e.tmo = !give_ack; e.rw = give_ack ? rw : 1'b0; e.m2r = m2r;
            e.rd = rd; e.alu = addr; e.data = give_ack ? rdata : 16'hFFFF;
            e.chk_data = !wr || !give_ack; e.ret = give_ack && ret_f && !wr;
            wbq.push_back(e);
         end
         next();
      end
      dmem_ack = 0;
   endtask

   int t_req, t_stall, t_valid;

   initial begin
      rst_n = 0; reg_rd_in = 0; alu_result = 0; sw_data = 0; dmem_rdata = 0;
      idle(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid_out", valid_out, 1'b0);
      check("rst_dmem_req", dmem_req, 1'b0);
      check("rst_stall_out", stall_out, 1'b0);
      check("rst_pc", PC_stack_pointer, 16'h0000);
      check("rst_mem_err", mem_err, 1'b0);
      check("rst_alu_result_out", alu_result_out, 16'h0000);
      next();
      rst_n = 1; chk_en = 1;
      idle(1);
      dmem_ack = 1; dmem_rdata = 16'h1111;
      next();
      idle(1);

      t_req = req_hi; t_stall = stall_hi;
      mem_op(1, 0, 0, 0, 1, 1, 4'd3, 16'h0040, 16'h0000, 3, 16'hBEEF, 1);
      idle(0);
      @(negedge clk);
      check("load_valid", valid_out, 1'b1);
      check("load_data", mem_data_out, 16'hBEEF);
      check("load_rd", reg_rd_out, 4'd3);
      next();
      check("load_req_cycles", req_hi - t_req, 4);
      check("load_stall_cycles", stall_hi - t_stall, 5);

      mem_op(0, 0, 1, 0, 0, 0, 4'hF, 16'h00FF, 16'h0123, 0, 16'h0000, 1);
      idle(1);
      mem_op(1, 1, 0, 0, 0, 0, 4'd2, 16'h0200, 16'hCAFE, 1, 16'h0000, 1);
      idle(1);
      mem_op(0, 0, 0, 1, 0, 0, 4'hF, 16'h00FE, 16'h0000, 2, 16'h0456, 1);
      idle(0);
      @(negedge clk);
      check("ret_pulse", ret_wb, 1'b1);
      check("ret_pc", PC_stack_pointer, 16'h0456);
      next();
      @(negedge clk);
      check("ret_pulse_end", ret_wb, 1'b0);
      next();

      mem_op(1, 0, 0, 0, 1, 1, 4'd4, 16'h0010, 16'h0000, 0, 16'h1234, 1);
      mem_op(1, 0, 0, 0, 1, 1, 4'd5, 16'h0011, 16'h0000, 1, 16'h5678, 1);
      idle(2);

      t_req = req_hi; t_stall = stall_hi; t_valid = valid_hi;
      alu_op(4'd1, 16'h0007, 1);
      alu_op(4'd2, 16'h0100, 1);
      alu_op(4'd6, 16'hFFFE, 0);
      idle(1);
      check("add_valid_cycles", valid_hi - t_valid, 3);
      check("add_no_stall", stall_hi - t_stall, 0);
      check("add_no_req", req_hi - t_req, 0);

      valid_in = 1; MemRead_in = 1; RegWrite_in = 1; mem_to_reg_in = 1; reg_rd_in = 4'd9;
      alu_result = 16'h0030; sw_data = 16'h0000;
      exp_stall = 1; exp_req = 0;
      next();
      exp_req = 1; exp_we = 0; exp_addr = 16'h0030; exp_wdata = 16'h0000;
      next();
      rst_n = 0;
      next();
      rst_n = 1; idle(0); dmem_ack = 1; dmem_rdata = 16'h7777;
      wbq.delete(); model_pc = '0; model_err = 0;
      @(negedge clk);
      check("rstreq_dmem_req", dmem_req, 1'b0);
      check("rstreq_valid", valid_out, 1'b0);
      check("rstreq_rd", reg_rd_out, 4'd0);
      check("rstreq_alu", alu_result_out, 16'h0000);
      check("rstreq_data", mem_data_out, 16'h0000);
      check("rstreq_pc", PC_stack_pointer, 16'h0000);
      check("rstreq_addr", dmem_addr, 16'h0000);
      next();
      idle(2);
      alu_op(4'd7, 16'h4242, 1);
      idle(2);

`ifdef MEM_TIMEOUT_EN
      mem_op(1, 0, 0, 0, 1, 1, 4'd8, 16'h0050, 16'h0000, 3, 16'h0000, 0);
      idle(0);
      @(negedge clk);
      check("tmo_data", mem_data_out, 16'hFFFF);
      check("tmo_regwrite", RegWrite_out, 1'b0);
      check("tmo_err", mem_err, 1'b1);
      next();
      idle(3);
      rst_n = 0;
      next();
      rst_n = 1; model_err = 0; model_pc = '0;
      idle(2);
`endif

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
